// File: rtl/vc_mem_pkg.sv
// Shared definitions for the memory-side arbiters: owner encoding, arbiter FSM states
// and the line-tag width derived from address width and line size.
package vc_mem_pkg;

  localparam int PA_DEFAULT          = 24;
  localparam int LINE_LENGTH_DEFAULT = 4;

  function automatic int tagWidth(input int pa, input int lineLength);
    return pa - $clog2(lineLength);
  endfunction

  localparam int TAG_W = tagWidth(PA_DEFAULT, LINE_LENGTH_DEFAULT);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2,
    OWN_X    = 2'd3
  } owner_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    TURN = 2'd2
  } state_e;

endpackage

// File: rtl/qspi_arb_pick.sv
// Winner selection for the QSPI arbiter: starved icache, then starved aux,
// then the fixed order dcache > icache > aux.
module qspi_arb_pick
  import vc_mem_pkg::*;
(
  input  logic   iReq_i,
  input  logic   dReq_i,
  input  logic   xReq_i,
  input  logic   iStarved_i,
  input  logic   xStarved_i,
  output owner_e winner_o
);

  always_comb begin
    winner_o = OWN_NONE;
    if (iReq_i && iStarved_i) begin
      winner_o = OWN_I;
    end else if (xReq_i && xStarved_i) begin
      winner_o = OWN_X;
    end else if (dReq_i) begin
      winner_o = OWN_D;
    end else if (iReq_i) begin
      winner_o = OWN_I;
    end else if (xReq_i) begin
      winner_o = OWN_X;
    end
  end

endmodule

// File: rtl/qspi_arb.sv
// Arbiter/sequencer sharing the single QSPI line engine between icache, dcache and
// the aux port: holds the grant for a whole line, routes strobes, starvation and timeout.
module qspi_arb
  import vc_mem_pkg::*;
#(
  parameter int PA          = PA_DEFAULT,
  parameter int LINE_LENGTH = LINE_LENGTH_DEFAULT,
  parameter int STARVE      = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               i_req,
  input  logic [PA-$clog2(LINE_LENGTH)-1:0]  i_tag,
  input  logic [1:0]                         i_mem,
  input  logic                               d_req,
  input  logic                               d_write,
  input  logic [PA-$clog2(LINE_LENGTH)-1:0]  d_tag,
  input  logic [1:0]                         d_mem,
  input  logic [3:0]                         d_wdata,
  input  logic                               x_req,
  input  logic                               x_write,
  input  logic [PA-$clog2(LINE_LENGTH)-1:0]  x_tag,
  input  logic [1:0]                         x_mem,
  input  logic [3:0]                         x_wdata,
  output logic                               i_gnt,
  output logic                               d_gnt,
  output logic                               x_gnt,
  output logic                               i_done,
  output logic                               d_done,
  output logic                               x_done,
  output logic                               err,
  output logic                               i_wstrobe,
  output logic                               d_wstrobe,
  output logic                               x_wstrobe,
  output logic                               d_rstrobe,
  output logic                               x_rstrobe,
  output logic                               q_req,
  output logic                               q_i_d,
  output logic                               q_write,
  output logic [PA-$clog2(LINE_LENGTH)-1:0]  q_tag,
  output logic [1:0]                         q_mem,
  output logic [3:0]                         q_wdata,
  input  logic                               q_wstrobe,
  input  logic                               q_rstrobe,
  input  logic                               q_done
);

  localparam int TW     = tagWidth(PA, LINE_LENGTH);
  localparam int WAIT_W = $clog2(STARVE + 1);
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [WAIT_W-1:0] iWait_q, iWait_d;
  logic [WAIT_W-1:0] xWait_q, xWait_d;
  logic [CNT_W-1:0]  tmoCnt_q, tmoCnt_d;
  logic              abort_q, abort_d;

  owner_e winner;
  logic   anyReq;
  logic   iStarved;
  logic   xStarved;
  logic   tmoHit;

  assign anyReq   = i_req | d_req | x_req;
  assign iStarved = (iWait_q == WAIT_W'(STARVE));
  assign xStarved = (xWait_q == WAIT_W'(STARVE));
  assign tmoHit   = (tmoCnt_q == CNT_W'(TIMEOUT));

  qspi_arb_pick uPick (
    .iReq_i     (i_req),
    .dReq_i     (d_req),
    .xReq_i     (x_req),
    .iStarved_i (iStarved),
    .xStarved_i (xStarved),
    .winner_o   (winner)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= OWN_NONE;
      iWait_q  <= '0;
      xWait_q  <= '0;
      tmoCnt_q <= '0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      iWait_q  <= iWait_d;
      xWait_q  <= xWait_d;
      tmoCnt_q <= tmoCnt_d;
      abort_q  <= abort_d;
    end
  end

  // Every IDLE cycle is an arbitration point, so wait counters only move there.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    iWait_d  = iWait_q;
    xWait_d  = xWait_q;
    tmoCnt_d = tmoCnt_q;
    abort_d  = abort_q;
    case (state_q)
      IDLE: begin
        abort_d  = 1'b0;
        tmoCnt_d = '0;
        if (anyReq) begin
          state_d = BUSY;
          owner_d = winner;
        end
        if (!i_req || (winner == OWN_I)) begin
          iWait_d = '0;
        end else if (!iStarved) begin
          iWait_d = iWait_q + 1'b1;
        end
        if (!x_req || (winner == OWN_X)) begin
          xWait_d = '0;
        end else if (!xStarved) begin
          xWait_d = xWait_q + 1'b1;
        end
      end
      BUSY: begin
        if (q_done || tmoHit) begin
          state_d = TURN;
          abort_d = !q_done;
        end else begin
          tmoCnt_d = tmoCnt_q + 1'b1;
        end
      end
      TURN: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
      default: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  // An icache owner is read-only, so its write flag, write data and rstrobe stay 0.
  always_comb begin
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    x_gnt     = 1'b0;
    i_done    = 1'b0;
    d_done    = 1'b0;
    x_done    = 1'b0;
    err       = 1'b0;
    i_wstrobe = 1'b0;
    d_wstrobe = 1'b0;
    x_wstrobe = 1'b0;
    d_rstrobe = 1'b0;
    x_rstrobe = 1'b0;
    q_req     = 1'b0;
    q_i_d     = 1'b0;
    q_write   = 1'b0;
    q_tag     = '0;
    q_mem     = '0;
    q_wdata   = '0;
    if (state_q == BUSY) begin
      q_req = 1'b1;
      case (owner_q)
        OWN_I: begin
          i_gnt     = 1'b1;
          q_i_d     = 1'b1;
          q_tag     = i_tag;
          q_mem     = i_mem;
          i_wstrobe = q_wstrobe;
        end
        OWN_D: begin
          d_gnt     = 1'b1;
          q_write   = d_write;
          q_tag     = d_tag;
          q_mem     = d_mem;
          q_wdata   = d_wdata;
          d_wstrobe = q_wstrobe;
          d_rstrobe = q_rstrobe;
        end
        OWN_X: begin
          x_gnt     = 1'b1;
          q_write   = x_write;
          q_tag     = x_tag;
          q_mem     = x_mem;
          q_wdata   = x_wdata;
          x_wstrobe = q_wstrobe;
          x_rstrobe = q_rstrobe;
        end
        OWN_NONE: begin
          q_req = 1'b0;
        end
        default: begin
          q_req = 1'b0;
        end
      endcase
    end else if (state_q == TURN) begin
      err = abort_q;
      case (owner_q)
        OWN_I:    i_done = 1'b1;
        OWN_D:    d_done = 1'b1;
        OWN_X:    x_done = 1'b1;
        default:  err    = 1'b0;
      endcase
    end
  end

  logic [TW-1:0] unusedTagCheck;
  assign unusedTagCheck = q_tag;

endmodule

// File: tb/tb_qspi_arb.sv
// Directed scoreboard bench for qspi_arb: expected grants are queued as requests are
// driven and popped when a grant appears; done/err/timing checked per transfer.
module tb_qspi_arb;
  import vc_mem_pkg::*;

  localparam int STARVE  = 4;
  localparam int TIMEOUT = 255;
  localparam int TW      = TAG_W;

  typedef struct {
    logic [1:0]    own;
    logic [TW-1:0] tag;
    logic [1:0]    mem;
    logic          wr;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req, d_req, x_req;
  logic          d_write, x_write;
  logic [TW-1:0] i_tag, d_tag, x_tag;
  logic [1:0]    i_mem, d_mem, x_mem;
  logic [3:0]    d_wdata, x_wdata;
  logic          i_gnt, d_gnt, x_gnt;
  logic          i_done, d_done, x_done, err;
  logic          i_wstrobe, d_wstrobe, x_wstrobe, d_rstrobe, x_rstrobe;
  logic          q_req, q_i_d, q_write;
  logic [TW-1:0] q_tag;
  logic [1:0]    q_mem;
  logic [3:0]    q_wdata;
  logic          q_wstrobe, q_rstrobe, q_done;

  exp_t       sb[$];
  logic [1:0] curOwn;
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  qspi_arb #(.PA(24), .LINE_LENGTH(4), .STARVE(STARVE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_tag(i_tag), .i_mem(i_mem),
    .d_req(d_req), .d_write(d_write), .d_tag(d_tag), .d_mem(d_mem), .d_wdata(d_wdata),
    .x_req(x_req), .x_write(x_write), .x_tag(x_tag), .x_mem(x_mem), .x_wdata(x_wdata),
    .i_gnt(i_gnt), .d_gnt(d_gnt), .x_gnt(x_gnt),
    .i_done(i_done), .d_done(d_done), .x_done(x_done), .err(err),
    .i_wstrobe(i_wstrobe), .d_wstrobe(d_wstrobe), .x_wstrobe(x_wstrobe),
    .d_rstrobe(d_rstrobe), .x_rstrobe(x_rstrobe),
    .q_req(q_req), .q_i_d(q_i_d), .q_write(q_write), .q_tag(q_tag), .q_mem(q_mem),
    .q_wdata(q_wdata), .q_wstrobe(q_wstrobe), .q_rstrobe(q_rstrobe), .q_done(q_done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pushExp(input logic [1:0] own, input logic [TW-1:0] tag,
                         input logic [1:0] mem, input logic wr);
    exp_t e;
    e.own = own; e.tag = tag; e.mem = mem; e.wr = wr;
    sb.push_back(e);
  endtask

  task automatic gotoCycle(input int n);
    while (cyc < n) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [2:0] doneMask(input logic [1:0] own);
    case (own)
      2'd1:    return 3'b001;
      2'd2:    return 3'b010;
      2'd3:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // Returns at the negedge of the grant cycle with the popped entry checked.
  task automatic awaitGrant(output int gcyc);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!(i_gnt || d_gnt || x_gnt) && n < 600) begin
      @(negedge clk);
      n++;
    end
    gcyc = cyc;
    checkOutput("grantInTime", 32'(n < 600), 1);
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL scoreboard observed=grant expected=no grant");
      curOwn = 2'd0;
    end else begin
      e = sb.pop_front();
      curOwn = e.own;
      checkOutput("gntOnehot", $countones({i_gnt, d_gnt, x_gnt}), 1);
      checkOutput("owner", {30'd0, x_gnt | d_gnt, x_gnt | i_gnt}, {30'd0, e.own});
      checkOutput("qTag", 32'(q_tag), 32'(e.tag));
      checkOutput("qMem", 32'(q_mem), 32'(e.mem));
      checkOutput("qWrite", 32'(q_write), 32'(e.wr));
      checkOutput("qIdSel", 32'(q_i_d), 32'(e.own == 2'd1));
      checkOutput("qReq", 32'(q_req), 1);
    end
  endtask

  // Starts at a negedge inside BUSY; returns at the drive point two cycles after done.
  task automatic applyStimulus(input int busyCycles, input bit expTimeout, input logic [2:0] dropMask);
    if (expTimeout) begin
      repeat (TIMEOUT) @(posedge clk);
      @(negedge clk);
      checkOutput("busyAtLimit", 32'(q_req), 1);
      checkOutput("noEarlyDone", 32'({x_done, d_done, i_done}), 0);
      @(negedge clk);
    end else begin
      repeat (busyCycles) @(posedge clk);
      #1 q_done = 1'b1;
      @(posedge clk);
      #1 q_done = 1'b0;
      @(negedge clk);
    end
    checkOutput("donePulse", 32'({x_done, d_done, i_done}), 32'(doneMask(curOwn)));
    checkOutput("errFlag", 32'(err), 32'(expTimeout));
    checkOutput("gntDrop", 32'({x_gnt, d_gnt, i_gnt}), 0);
    checkOutput("qReqDrop", 32'(q_req), 0);
    @(posedge clk); #1;
    if (dropMask[0]) i_req = 1'b0;
    if (dropMask[1]) d_req = 1'b0;
    if (dropMask[2]) x_req = 1'b0;
    @(negedge clk);
    checkOutput("doneOnce", 32'({x_done, d_done, i_done, err}), 0);
    checkOutput("gapNoReq", 32'(q_req), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int g, r, dW, iW, xW;
    reset = 1'b1;
    {i_req, d_req, x_req, d_write, x_write} = '0;
    i_tag = '0; d_tag = '0; x_tag = '0;
    i_mem = '0; d_mem = '0; x_mem = '0;
    d_wdata = '0; x_wdata = '0;
    {q_wstrobe, q_rstrobe, q_done} = '0;
    curOwn = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("resetGnt", 32'({i_gnt, d_gnt, x_gnt, q_req}), 0);
    checkOutput("resetDone", 32'({i_done, d_done, x_done, err}), 0);
    checkOutput("resetQBus", 32'({q_i_d, q_write, q_mem, q_wdata}), 0);

    // Single icache request, then a held request re-granted after the turnaround.
    gotoCycle(10);
    i_req = 1'b1; i_tag = 22'h12345; i_mem = 2'd2;
    pushExp(2'd1, 22'h12345, 2'd2, 1'b0);
    awaitGrant(g);
    checkOutput("grantCycle", g, 11);
    applyStimulus(9, 1'b0, 3'b000);
    pushExp(2'd1, 22'h12345, 2'd2, 1'b0);
    awaitGrant(g);
    checkOutput("backToBack", g, 23);
    applyStimulus(2, 1'b0, 3'b001);

    // Simultaneous requests: d, then i, then x.
    i_req = 1'b1; i_tag = 22'h0AAAA; i_mem = 2'd1;
    d_req = 1'b1; d_write = 1'b1; d_tag = 22'h1BBBB; d_mem = 2'd3;
    x_req = 1'b1; x_write = 1'b0; x_tag = 22'h2CCCC; x_mem = 2'd0;
    pushExp(2'd2, 22'h1BBBB, 2'd3, 1'b1);
    pushExp(2'd1, 22'h0AAAA, 2'd1, 1'b0);
    pushExp(2'd3, 22'h2CCCC, 2'd0, 1'b0);
    awaitGrant(g); applyStimulus(3, 1'b0, 3'b010);
    awaitGrant(g); applyStimulus(3, 1'b0, 3'b001);
    awaitGrant(g); applyStimulus(3, 1'b0, 3'b100);

    // Starvation: d wins four times, then starved i, then starved x ahead of d.
    i_req = 1'b1; d_req = 1'b1; d_write = 1'b0; x_req = 1'b1; x_write = 1'b1;
    for (int k = 0; k < STARVE; k++) pushExp(2'd2, 22'h1BBBB, 2'd3, 1'b0);
    pushExp(2'd1, 22'h0AAAA, 2'd1, 1'b0);
    pushExp(2'd3, 22'h2CCCC, 2'd0, 1'b1);
    for (int k = 0; k < STARVE; k++) begin
      awaitGrant(g); applyStimulus(1, 1'b0, 3'b000);
    end
    awaitGrant(g); applyStimulus(1, 1'b0, 3'b000);
    awaitGrant(g); applyStimulus(1, 1'b0, 3'b111);

    // Strobe isolation and write data routing with a pushing dcache owner.
    d_req = 1'b1; d_write = 1'b1; x_req = 1'b1; x_write = 1'b0;
    pushExp(2'd2, 22'h1BBBB, 2'd3, 1'b1);
    pushExp(2'd3, 22'h2CCCC, 2'd0, 1'b0);
    awaitGrant(g);
    dW = 0; iW = 0; xW = 0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      q_wstrobe = (k % 2 == 0);
      q_rstrobe = (k % 4 == 1);
      d_wdata = 4'(k);
      x_wdata = 4'(15 - k);
      @(negedge clk);
      dW += int'(d_wstrobe); iW += int'(i_wstrobe); xW += int'(x_wstrobe);
      checkOutput("qWdata", 32'(q_wdata), 32'(k));
      checkOutput("dRstrobe", 32'({x_rstrobe, d_rstrobe}), 32'(k % 4 == 1));
    end
    @(posedge clk); #1;
    q_wstrobe = 1'b0; q_rstrobe = 1'b0;
    @(negedge clk);
    checkOutput("dWstrobeCount", dW, 8);
    checkOutput("otherWstrobe", iW + xW, 0);
    applyStimulus(1, 1'b0, 3'b010);

    // x owns with no q_done: abort with err after TIMEOUT+1 cycles.
    awaitGrant(g);
    applyStimulus(0, 1'b1, 3'b100);

    // q_done exactly when the counter hits TIMEOUT is a normal completion.
    x_req = 1'b1;
    pushExp(2'd3, 22'h2CCCC, 2'd0, 1'b0);
    awaitGrant(g);
    applyStimulus(TIMEOUT, 1'b0, 3'b100);

    // q_done while idle is ignored.
    q_done = 1'b1;
    @(negedge clk);
    checkOutput("idleQReq", 32'(q_req), 0);
    @(posedge clk); #1 q_done = 1'b0;
    @(negedge clk);
    checkOutput("idleDone", 32'({x_done, d_done, i_done, err}), 0);
    @(posedge clk); #1;

    // Reset mid-transfer abandons the line; the pending request is re-granted.
    i_req = 1'b1;
    pushExp(2'd1, 22'h0AAAA, 2'd1, 1'b0);
    awaitGrant(g);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    r = cyc;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("rstMidGnt", 32'({i_gnt, d_gnt, x_gnt, q_req}), 0);
    checkOutput("rstMidDone", 32'({i_done, d_done, x_done, err}), 0);
    pushExp(2'd1, 22'h0AAAA, 2'd1, 1'b0);
    awaitGrant(g);
    checkOutput("postRstGrant", g, r + 2);
    applyStimulus(2, 1'b0, 3'b001);
    checkOutput("sbDrained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
